// File: rtl/ysyx_25020037_rd_arbiter_pkg.sv
// Shared constants and types for the two-master AXI4 read arbiter:
// AXI field widths, FSM state encoding and master indices.
package ysyx_25020037_pkg;

   localparam int AXI_AW     = 32;
   localparam int AXI_DW     = 32;
   localparam int AXI_IDW    = 4;
   localparam int AXI_LENW   = 8;
   localparam int AXI_SIZEW  = 3;
   localparam int AXI_BURSTW = 2;
   localparam int AXI_RESPW  = 2;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_DATA = 2'd2
   } arb_state_e;

   localparam logic ARB_M_IFU = 1'b0;
   localparam logic ARB_M_LSU = 1'b1;

   // Routed payloads, packed so the steering muxes move whole beats at once.
   typedef struct packed {
      logic [AXI_AW-1:0]     addr;
      logic [AXI_IDW-1:0]    id;
      logic [AXI_LENW-1:0]   len;
      logic [AXI_SIZEW-1:0]  size;
      logic [AXI_BURSTW-1:0] burst;
   } ar_pld_t;

   typedef struct packed {
      logic [AXI_RESPW-1:0] resp;
      logic [AXI_DW-1:0]    data;
      logic                 last;
      logic [AXI_IDW-1:0]   id;
   } r_pld_t;

endpackage

// File: rtl/ysyx_25020037_rd_arbiter_if.sv
// AXI4 read-channel bundle (AR + R). The master modport is the side that issues
// addresses; the slave modport is the side that answers with data.
interface ysyx_25020037_rd_arbiter_if;
   import ysyx_25020037_pkg::*;

   logic                  arvalid;
   logic                  arready;
   logic [AXI_AW-1:0]     araddr;
   logic [AXI_IDW-1:0]    arid;
   logic [AXI_LENW-1:0]   arlen;
   logic [AXI_SIZEW-1:0]  arsize;
   logic [AXI_BURSTW-1:0] arburst;
   logic                  rvalid;
   logic                  rready;
   logic [AXI_RESPW-1:0]  rresp;
   logic [AXI_DW-1:0]     rdata;
   logic                  rlast;
   logic [AXI_IDW-1:0]    rid;

   modport master (
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  arready, rvalid, rresp, rdata, rlast, rid
   );

   modport slave (
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output arready, rvalid, rresp, rdata, rlast, rid
   );

endinterface

// File: rtl/ysyx_25020037_rd_arbiter_pick.sv
// Combinational grant picker: a lone request wins outright; a conflict goes to
// the master not served last (round-robin) or to the LSU (fixed priority).
module ysyx_25020037_arb_pick
   import ysyx_25020037_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   input  logic rr_en,
   output logic win
);

   always_comb begin
      win = ARB_M_IFU;
      if (req1 && !req0)
         win = ARB_M_LSU;
      else if (req0 && req1)
         win = rr_en ? ~last : ARB_M_LSU;
   end

endmodule

// File: rtl/ysyx_25020037_rd_arbiter.sv
// Two-master AXI4 read arbiter (m0 = IFU, m1 = LSU) onto one downstream port.
// Define YSYX_25020037_ARB_RR_EN for round-robin; otherwise LSU has fixed priority.
module ysyx_25020037_rd_arbiter
   import ysyx_25020037_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   ysyx_25020037_rd_arbiter_if.slave     m0,
   ysyx_25020037_rd_arbiter_if.slave     m1,
   ysyx_25020037_rd_arbiter_if.master    s
);

   arb_state_e state, nxt;
   logic       grant;
   logic       last;
   logic       rr_en;
   logic       win;
   logic       any_req;
   logic       ar_hs;
   logic       r_done;

   ar_pld_t    m0_ar, m1_ar, s_ar;
   r_pld_t     s_r, m0_r, m1_r;

   logic       s_arvalid_w, s_rready_w;
   logic       m0_arready_w, m1_arready_w;
   logic       m0_rvalid_w, m1_rvalid_w;

   assign any_req = m0.arvalid | m1.arvalid;
   assign ar_hs   = s_arvalid_w & s.arready;
   assign r_done  = s.rvalid & s_rready_w & s.rlast;

`ifdef YSYX_25020037_ARB_RR_EN
   assign rr_en = 1'b1;

   // Remembers who finished most recently so the next conflict goes the other way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last <= ARB_M_LSU;
      else if (state == ARB_DATA && r_done)
         last <= grant;
   end
`else
   assign rr_en = 1'b0;
   assign last  = ARB_M_LSU;
`endif

   ysyx_25020037_arb_pick u_pick (
      .req0  (m0.arvalid),
      .req1  (m1.arvalid),
      .last  (last),
      .rr_en (rr_en),
      .win   (win)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ARB_IDLE;
         grant <= ARB_M_IFU;
      end else begin
         state <= nxt;
         if (state == ARB_IDLE && any_req)
            grant <= win;
      end
   end

   // A master dropping arvalid in ADDR is an AXI violation; we simply wait.
   always_comb begin
      nxt = state;
      case (state)
         ARB_IDLE: if (any_req) nxt = ARB_ADDR;
         ARB_ADDR: if (ar_hs)   nxt = ARB_DATA;
         ARB_DATA: if (r_done)  nxt = ARB_IDLE;
         default:               nxt = ARB_IDLE;
      endcase
   end

   assign m0_ar = {m0.araddr, m0.arid, m0.arlen, m0.arsize, m0.arburst};
   assign m1_ar = {m1.araddr, m1.arid, m1.arlen, m1.arsize, m1.arburst};
   assign s_r   = {s.rresp, s.rdata, s.rlast, s.rid};

   always_comb begin
      s_arvalid_w  = 1'b0;
      s_ar         = '0;
      s_rready_w   = 1'b0;
      m0_arready_w = 1'b0;
      m1_arready_w = 1'b0;
      m0_rvalid_w  = 1'b0;
      m1_rvalid_w  = 1'b0;
      m0_r         = '0;
      m1_r         = '0;
      case (state)
         ARB_ADDR: begin
            if (grant == ARB_M_LSU) begin
               s_arvalid_w  = m1.arvalid;
               s_ar         = m1_ar;
               m1_arready_w = s.arready;
            end else begin
               s_arvalid_w  = m0.arvalid;
               s_ar         = m0_ar;
               m0_arready_w = s.arready;
            end
         end
         ARB_DATA: begin
            if (grant == ARB_M_LSU) begin
               s_rready_w  = m1.rready;
               m1_rvalid_w = s.rvalid;
               m1_r        = s_r;
            end else begin
               s_rready_w  = m0.rready;
               m0_rvalid_w = s.rvalid;
               m0_r        = s_r;
            end
         end
         default: ;
      endcase
   end

   assign s.arvalid = s_arvalid_w;
   assign {s.araddr, s.arid, s.arlen, s.arsize, s.arburst} = s_ar;
   assign s.rready  = s_rready_w;

   assign m0.arready = m0_arready_w;
   assign m1.arready = m1_arready_w;
   assign m0.rvalid  = m0_rvalid_w;
   assign m1.rvalid  = m1_rvalid_w;
   assign {m0.rresp, m0.rdata, m0.rlast, m0.rid} = m0_r;
   assign {m1.rresp, m1.rdata, m1.rlast, m1.rid} = m1_r;

endmodule

// File: doc/ysyx_25020037_rd_arbiter.md
# ysyx_25020037_rd_arbiter

Two-master AXI4 read-channel arbiter that shares one downstream read port (CLINT/SoC crossbar) between the IFU (master 0) and LSU (master 1). It grants one master per read transaction, forwards the AR beat, routes every R beat back to the owner, and releases the port only after the `rlast` handshake. It sits between the core's fetch/load units and the device read slaves.

## Interface
- No parameters. Widths are fixed: addr/data 32, id 4, len 8, size 3, burst 2, resp 2.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `m0_*`  upstream port for IFU; `m1_*`  upstream port for LSU. Each port has:
  - `arvalid`, `araddr[31:0]`, `arid[3:0]`, `arlen[7:0]`, `arsize[2:0]`, `arburst[1:0]`, `rready`: inputs.
  - `arready`, `rvalid`, `rresp[1:0]`, `rdata[31:0]`, `rlast`, `rid[3:0]`: outputs.
- `s_*`  downstream port, same signal set with directions mirrored:
  - `s_arvalid`, `s_araddr`, `s_arid`, `s_arlen`, `s_arsize`, `s_arburst`, `s_rready`: outputs.
  - `s_arready`, `s_rvalid`, `s_rresp`, `s_rdata`, `s_rlast`, `s_rid`: inputs.

## Operation
- Registers: `state` (IDLE, ADDR, DATA), `grant` (1 bit, owning master), and `last` (1 bit, master served most recently; used only with round-robin).
- IDLE
  - All `s_arvalid`, `m*_arready` and `m*_rvalid` are 0.
  - If any `m*_arvalid` is high: latch `grant` per the priority rule and go to ADDR.
- ADDR
  - `s_ar*` = granted master's `ar*`. `s_arvalid` = granted `arvalid`. Granted `arready` = `s_arready`.
  - The other master's `arready` is 0.
  - On `s_arvalid & s_arready`, go to DATA.
- DATA
  - Granted `rvalid`/`rresp`/`rdata`/`rlast`/`rid` = `s_r*`. `s_rready` = granted `rready`.
  - The other master's `rvalid` is 0. Its `rdata`/`rresp`/`rid`/`rlast` are driven 0.
  - On `s_rvalid & s_rready & s_rlast`, go to IDLE and set `last <= grant`.
  - Beats with `rlast`=0 keep the state in DATA.
- Outside DATA, `s_rready` = 0. Outside ADDR, `s_ar*` payload is driven 0.
- `rresp` (including SLVERR/DECERR) and `rid` pass through unmodified. The arbiter never generates responses.
- A master that drops `arvalid` in ADDR before the handshake violates AXI. The arbiter keeps `grant` and stays in ADDR.
- A request arriving while the port is busy waits, with `arready`=0, until the arbiter returns to IDLE.

## Timing
- Reset (async, takes effect immediately): `state`=IDLE, `grant`=0, `last`=1. All valid/ready outputs are 0 and all payload outputs are 0.
- Reset asserted mid-transaction aborts it. Nothing is replayed.
- All outputs are combinational from `state`/`grant` and the routed inputs. There are no registered data paths.
- Grant latency: one cycle. `arvalid` seen in IDLE at cycle N gives `s_arvalid` at N+1.
- Turnaround: the final `rlast` handshake at cycle N puts the arbiter in IDLE at N+1. A pending request reaches ADDR at N+2.
- Minimum single-beat transaction is 3 cycles (IDLE, ADDR, DATA), assuming the slave responds immediately.
- Simultaneous `m0_arvalid` and `m1_arvalid` in IDLE are resolved by the priority rule only.

## Configuration
- `YSYX_25020037_ARB_RR_EN`
  - Defined: round-robin. On a conflict, grant the master that is not `last`. With `last` reset to 1, m0 wins the first conflict.
  - Undefined: fixed priority, LSU (m1) always wins. `last` is not implemented and has no effect.
- Single requests are granted immediately in both modes.

## Structure
- Shared package `ysyx_25020037_pkg` holds:
  - the state encoding constants `ARB_IDLE`, `ARB_ADDR`, `ARB_DATA`;
  - the master index constants `ARB_M_IFU`=0 and `ARB_M_LSU`=1;
  - the AXI width constants.
- One natural sub-module: `ysyx_25020037_arb_pick`, the combinational grant picker. Inputs: two requests, `last`, and the mode. Output: the winning index.
- Steering muxes stay in the top module.

## Test plan
- Single IFU read: m0 `araddr`=0x02000000, `arlen`=0, with slave `rdata`=0x12345678 → `s_arvalid` one cycle after the request. m0 receives 0x12345678 with `rlast`=1. m1 sees no `rvalid`.
- Simultaneous requests, RR undefined: m1 is granted first and m0 is served after m1's `rlast`. With RR defined after reset, m0 goes first, then m1.
- Back-to-back RR fairness: both masters hold `arvalid` continuously for 4 transactions → grant order alternates 0, 1, 0, 1.
- Burst with backpressure: m1 `arlen`=3 and `rready` toggling each cycle → 4 beats delivered in order, `s_rready` mirrors m1 `rready`, and the arbiter stays in DATA until beat 4 (`rlast`).
- Slave stalls: `s_arready`=0 for 5 cycles in ADDR → `s_ar*` held stable and granted `arready` stays 0. `s_rresp`=2'b10 is forwarded unchanged.
- Reset during DATA after beat 2 of 4 → all valids are 0 immediately, and `state`=IDLE and `last`=1 after reset release.
